// File: rtl/trig_ctrl_pkg.sv
// trig_ctrl_pkg: state encodings, status bit map and detect bit index shared by the trigger run controller
package trig_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIRE = 3'd3,
        S_DONE = 3'd4
    } trig_state_t;
    localparam int ST_DONE         = 3;
    localparam int ST_TIMEOUT      = 4;
    localparam int ST_ABORTED      = 5;
    localparam int ST_ARM_IGN      = 6;
    localparam int ST_BUSY         = 7;
    localparam int DETECT_TRIG_BIT = 4;
endpackage

// File: rtl/trig_pulse_stretch.sv
// trig_pulse_stretch: loadable-width one-shot (width 0 acts as 1) with a synchronous kill that drops the pulse at once
module trig_pulse_stretch #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_kill,
    input  logic [W-1:0] i_width,
    output logic         o_pulse,
    output logic         o_last
);
    logic [W-1:0] r_cnt;
    logic         r_pulse;
    assign o_pulse = r_pulse;
    assign o_last  = r_pulse && (r_cnt == '0);
    always_ff @(posedge i_clk) begin
        if (i_rst || i_kill) begin
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_pulse <= 1'b1;
            r_cnt   <= (i_width == '0) ? '0 : i_width - W'(1);
        end else if (r_pulse) begin
            r_pulse <= (r_cnt != '0);
            r_cnt   <= (r_cnt == '0) ? '0 : r_cnt - W'(1);
        end
    end
endmodule

// File: rtl/trigger_seq_ctrl.sv
// trigger_seq_ctrl: shot sequencer for trigger_gen with atomic config shadowing, timeout, TOF capture and output trigger
module trigger_seq_ctrl
    import trig_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int SHOT_CNT_WIDTH     = 16,
    parameter int LOAD_CYCLES        = 2
) (
    input  logic                          i_rxclk,
    input  logic                          i_rst,
    input  logic                          i_cmd_arm,
    input  logic                          i_cmd_abort,
    input  logic                          i_cfg_auto_rearm,
    input  logic [15:0]                   i_cfg_trig_width,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_timeout,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_level_a,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_level_b,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_level_c,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_param_mul,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_param_off,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_cfg_init_delay,
    input  logic [7:0]                    i_tg_detect_pls,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_tg_pulse_tof,
    output logic                          o_tg_enable,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tg_level_a,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tg_level_b,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tg_level_c,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tg_param_mul,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tg_param_off,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tg_init_delay,
    output logic                          o_trig_out,
    output logic                          o_irq,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_tof_captured,
    output logic [SHOT_CNT_WIDTH-1:0]     o_shot_cnt,
    output logic [7:0]                    o_status
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    trig_state_t         r_state;
    logic [7:0]          r_load_cnt;
    logic [DW-1:0]       r_to_cnt, r_tof;
    logic [DW-1:0]       r_lvl_a, r_lvl_b, r_lvl_c, r_mul, r_off, r_dly;
    logic [SHOT_CNT_WIDTH-1:0] r_shot_cnt;
    logic r_det_d, r_tg_enable, r_irq, r_done, r_timeout, r_aborted, r_arm_ign;
    logic w_rise, w_arm_ok, w_reload, w_to_hit, w_fire, w_ps_last, w_unused;
    assign w_rise   = i_tg_detect_pls[DETECT_TRIG_BIT] && !r_det_d;
    assign w_arm_ok = (r_state == S_IDLE) && i_cmd_arm && !i_cmd_abort;
    assign w_reload = w_arm_ok || ((r_state == S_DONE) && i_cfg_auto_rearm && !i_cmd_abort);
    assign w_to_hit = (i_cfg_timeout != '0) && (r_to_cnt + DW'(1) == i_cfg_timeout);
    assign w_fire   = (r_state == S_RUN) && w_rise && !i_cmd_abort;
    assign w_unused = ^{i_tg_detect_pls[7:5], i_tg_detect_pls[3:0]};
    trig_pulse_stretch #(.W(16)) u_stretch (
        .i_clk   (i_rxclk),
        .i_rst   (i_rst),
        .i_start (w_fire),
        .i_kill  (i_cmd_abort),
        .i_width (i_cfg_trig_width),
        .o_pulse (o_trig_out),
        .o_last  (w_ps_last)
    );
    always_ff @(posedge i_rxclk) begin
        if (i_rst) begin
            r_lvl_a <= '0;
            r_lvl_b <= '0;
            r_lvl_c <= '0;
            r_mul   <= '0;
            r_off   <= '0;
            r_dly   <= '0;
        end else if (w_reload) begin
            r_lvl_a <= i_cfg_level_a;
            r_lvl_b <= i_cfg_level_b;
            r_lvl_c <= i_cfg_level_c;
            r_mul   <= i_cfg_param_mul;
            r_off   <= i_cfg_param_off;
            r_dly   <= i_cfg_init_delay;
        end
    end
    always_ff @(posedge i_rxclk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_load_cnt  <= '0;
            r_to_cnt    <= '0;
            r_tof       <= DW'(32'hFFFF);
            r_shot_cnt  <= '0;
            r_det_d     <= 1'b0;
            r_tg_enable <= 1'b0;
            r_irq       <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            r_arm_ign   <= 1'b0;
        end else begin
            r_irq   <= 1'b0;
            r_det_d <= (r_state != S_LOAD) && i_tg_detect_pls[DETECT_TRIG_BIT];
            if (w_reload) r_load_cnt <= 8'(LOAD_CYCLES - 1);
            if (i_cmd_abort) begin
                r_state     <= S_IDLE;
                r_tg_enable <= 1'b0;
                r_aborted   <= 1'b1;
            end else begin
                if (i_cmd_arm && r_state != S_IDLE) r_arm_ign <= 1'b1;
                case (r_state)
                    S_IDLE: if (w_arm_ok) begin
                        r_state   <= S_LOAD;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_aborted <= 1'b0;
                        r_arm_ign <= 1'b0;
                    end
                    S_LOAD: if (r_load_cnt == '0) begin
                        r_state     <= S_RUN;
                        r_tg_enable <= 1'b1;
                        r_to_cnt    <= '0;
                    end else begin
                        r_load_cnt <= r_load_cnt - 8'd1;
                    end
                    S_RUN: if (w_rise) begin
                        r_state <= S_FIRE;
                        r_tof   <= i_tg_pulse_tof;
                    end else if (w_to_hit) begin
                        r_state     <= S_IDLE;
                        r_tg_enable <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_irq       <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + DW'(1);
                    end
                    S_FIRE: if (w_ps_last) begin
                        r_state     <= S_DONE;
                        r_tg_enable <= 1'b0;
                        r_irq       <= 1'b1;
                        r_done      <= 1'b1;
                        r_shot_cnt  <= r_shot_cnt + SHOT_CNT_WIDTH'(1);
                    end
                    S_DONE: r_state <= i_cfg_auto_rearm ? S_LOAD : S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
    assign o_tg_enable     = r_tg_enable;
    assign o_tg_level_a    = r_lvl_a;
    assign o_tg_level_b    = r_lvl_b;
    assign o_tg_level_c    = r_lvl_c;
    assign o_tg_param_mul  = r_mul;
    assign o_tg_param_off  = r_off;
    assign o_tg_init_delay = r_dly;
    assign o_irq           = r_irq;
    assign o_tof_captured  = r_tof;
    assign o_shot_cnt      = r_shot_cnt;
    assign o_status        = {r_state != S_IDLE, r_arm_ign, r_aborted, r_timeout, r_done, r_state};
endmodule

// File: tb/tb_trigger_seq_ctrl.sv
// tb_trigger_seq_ctrl: directed scenario tests for trigger_seq_ctrl with hand-computed expectations
module tb_trigger_seq_ctrl;
    logic        clk, rst, arm, abort_c, auto_rearm;
    logic [15:0] trig_width;
    logic [31:0] timeout, level_a, level_b, level_c, param_mul, param_off, init_delay, tof_in;
    logic [7:0]  det;
    logic        tg_enable, trig_out, irq;
    logic [31:0] tg_level_a, tg_level_b, tg_level_c, tg_param_mul, tg_param_off, tg_init_delay, tof_captured;
    logic [15:0] shot_cnt;
    logic [7:0]  status;
    int n_tests = 0;
    int n_fail  = 0;
    trigger_seq_ctrl dut (
        .i_rxclk(clk), .i_rst(rst), .i_cmd_arm(arm), .i_cmd_abort(abort_c),
        .i_cfg_auto_rearm(auto_rearm), .i_cfg_trig_width(trig_width), .i_cfg_timeout(timeout),
        .i_cfg_level_a(level_a), .i_cfg_level_b(level_b), .i_cfg_level_c(level_c),
        .i_cfg_param_mul(param_mul), .i_cfg_param_off(param_off), .i_cfg_init_delay(init_delay),
        .i_tg_detect_pls(det), .i_tg_pulse_tof(tof_in),
        .o_tg_enable(tg_enable), .o_tg_level_a(tg_level_a), .o_tg_level_b(tg_level_b),
        .o_tg_level_c(tg_level_c), .o_tg_param_mul(tg_param_mul), .o_tg_param_off(tg_param_off),
        .o_tg_init_delay(tg_init_delay), .o_trig_out(trig_out), .o_irq(irq),
        .o_tof_captured(tof_captured), .o_shot_cnt(shot_cnt), .o_status(status)
    );
    initial clk = 1'b0;
    always #4 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_arm;
        arm = 1'b1;
        tick;
        arm = 1'b0;
    endtask
    task automatic do_abort;
        abort_c = 1'b1;
        tick;
        abort_c = 1'b0;
    endtask
    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_tests++; if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h exp 00", status); end
        n_tests++; if (tof_captured !== 32'h0000FFFF) begin n_fail++; $display("FAIL reset_tof: got %h exp 0000ffff", tof_captured); end
        n_tests++; if ({tg_enable, trig_out, irq} !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got %b exp 000", {tg_enable, trig_out, irq}); end
        n_tests++; if (shot_cnt !== 16'd0 || tg_level_a !== 32'd0) begin n_fail++; $display("FAIL reset_regs: got %h/%h exp 0/0", shot_cnt, tg_level_a); end
        rst = 1'b0;
        tick;
        n_tests++; if (status !== 8'h00 || tg_enable !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %h/%b exp 00/0", status, tg_enable); end
    endtask
    task automatic test_basic_shot;
        int hi, irqs;
        trig_width = 16'd5;
        level_a = 32'h1111_2222;
        param_mul = 32'h0001_8000;
        tof_in = 32'h0000_ABCD;
        do_arm;
        n_tests++; if (tg_enable !== 1'b0 || status[2:0] !== 3'd1) begin n_fail++; $display("FAIL basic_load1: got en=%b st=%0d exp 0/1", tg_enable, status[2:0]); end
        n_tests++; if (tg_level_a !== 32'h1111_2222 || tg_param_mul !== 32'h0001_8000) begin n_fail++; $display("FAIL basic_shadow: got %h/%h exp 11112222/00018000", tg_level_a, tg_param_mul); end
        tick;
        n_tests++; if (tg_enable !== 1'b0) begin n_fail++; $display("FAIL basic_load2: got en=%b exp 0", tg_enable); end
        tick;
        n_tests++; if (tg_enable !== 1'b1 || status[2:0] !== 3'd2) begin n_fail++; $display("FAIL basic_run: got en=%b st=%0d exp 1/2", tg_enable, status[2:0]); end
        repeat (97) tick;
        det = 8'h10;
        tick;
        tof_in = 32'h0000_5555;
        n_tests++; if (status[2:0] !== 3'd3 || trig_out !== 1'b1) begin n_fail++; $display("FAIL basic_fire: got st=%0d trig=%b exp 3/1", status[2:0], trig_out); end
        hi = 0;
        irqs = 0;
        for (int i = 0; i < 30; i++) begin
            hi += int'(trig_out);
            irqs += int'(irq);
            tick;
        end
        det = 8'h00;
        n_tests++; if (hi !== 5) begin n_fail++; $display("FAIL basic_width: got %0d exp 5", hi); end
        n_tests++; if (irqs !== 1) begin n_fail++; $display("FAIL basic_irq: got %0d exp 1", irqs); end
        n_tests++; if (tof_captured !== 32'h0000_ABCD) begin n_fail++; $display("FAIL basic_tof: got %h exp 0000abcd", tof_captured); end
        n_tests++; if (shot_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_shots: got %0d exp 1", shot_cnt); end
        n_tests++; if (status !== 8'h08 || tg_enable !== 1'b0) begin n_fail++; $display("FAIL basic_end: got %h/%b exp 08/0", status, tg_enable); end
    endtask
    task automatic test_timeout;
        int runs;
        logic seen;
        timeout = 32'd50;
        runs = 0;
        seen = 1'b0;
        do_arm;
        tick;
        tick;
        while (status[2:0] == 3'd2 && runs < 200) begin
            runs++;
            seen |= trig_out;
            tick;
        end
        n_tests++; if (runs !== 50) begin n_fail++; $display("FAIL timeout_cycles: got %0d exp 50", runs); end
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL timeout_irq: got %b exp 1", irq); end
        n_tests++; if (status !== 8'h10 || tg_enable !== 1'b0) begin n_fail++; $display("FAIL timeout_status: got %h/%b exp 10/0", status, tg_enable); end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL timeout_trig: got %b exp 0", seen); end
        tick;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL timeout_irq_len: got %b exp 0", irq); end
        timeout = 32'd0;
    endtask
    task automatic test_abort_fire;
        int irqs, hi;
        trig_width = 16'd10;
        do_arm;
        tick;
        tick;
        det = 8'h10;
        tick;
        tick;
        n_tests++; if (trig_out !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got %b exp 1", trig_out); end
        do_abort;
        det = 8'h00;
        n_tests++; if (trig_out !== 1'b0 || tg_enable !== 1'b0) begin n_fail++; $display("FAIL abort_kill: got trig=%b en=%b exp 0/0", trig_out, tg_enable); end
        n_tests++; if (status !== 8'h20) begin n_fail++; $display("FAIL abort_status: got %h exp 20", status); end
        irqs = 0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            irqs += int'(irq);
            hi += int'(trig_out);
            tick;
        end
        n_tests++; if (irqs !== 0 || hi !== 0) begin n_fail++; $display("FAIL abort_quiet: got irq=%0d trig=%0d exp 0/0", irqs, hi); end
        n_tests++; if (shot_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_shots: got %0d exp 1", shot_cnt); end
    endtask
    task automatic test_shadow;
        level_a = 32'hA1A1_0001;
        do_arm;
        tick;
        tick;
        level_a = 32'hB2B2_0002;
        init_delay = 32'h0000_0777;
        repeat (5) tick;
        n_tests++; if (tg_level_a !== 32'hA1A1_0001 || tg_init_delay !== 32'd0) begin n_fail++; $display("FAIL shadow_hold: got %h/%h exp a1a10001/0", tg_level_a, tg_init_delay); end
        do_abort;
        n_tests++; if (tg_level_a !== 32'hA1A1_0001) begin n_fail++; $display("FAIL shadow_abort: got %h exp a1a10001", tg_level_a); end
        do_arm;
        n_tests++; if (tg_level_a !== 32'hB2B2_0002 || tg_init_delay !== 32'h777) begin n_fail++; $display("FAIL shadow_rearm: got %h/%h exp b2b20002/777", tg_level_a, tg_init_delay); end
        n_tests++; if (status !== 8'h81) begin n_fail++; $display("FAIL shadow_clear: got %h exp 81", status); end
        do_abort;
    endtask
    task automatic test_auto_rearm;
        int lc, hi, guard;
        logic en_bad;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        trig_width = 16'd0;
        auto_rearm = 1'b1;
        do_arm;
        for (int s = 1; s <= 3; s++) begin
            lc = 0;
            en_bad = 1'b0;
            guard = 0;
            while (status[2:0] != 3'd2 && guard < 20) begin
                if (status[2:0] == 3'd1) begin
                    lc++;
                    en_bad |= tg_enable;
                end
                tick;
                guard++;
            end
            n_tests++; if (lc !== 2 || en_bad !== 1'b0) begin n_fail++; $display("FAIL auto_load%0d: got %0d cycles en=%b exp 2/0", s, lc, en_bad); end
            det = 8'h10;
            tick;
            det = 8'h00;
            if (s == 3) auto_rearm = 1'b0;
            hi = 0;
            guard = 0;
            while (status[2:0] != 3'd1 && status[2:0] != 3'd0 && guard < 20) begin
                hi += int'(trig_out);
                tick;
                guard++;
            end
            n_tests++; if (hi !== 1) begin n_fail++; $display("FAIL auto_width%0d: got %0d exp 1", s, hi); end
        end
        n_tests++; if (shot_cnt !== 16'd3) begin n_fail++; $display("FAIL auto_shots: got %0d exp 3", shot_cnt); end
        n_tests++; if (status !== 8'h08) begin n_fail++; $display("FAIL auto_end: got %h exp 08", status); end
    endtask
    task automatic test_same_cycle;
        int guard;
        arm = 1'b1;
        abort_c = 1'b1;
        tick;
        arm = 1'b0;
        abort_c = 1'b0;
        n_tests++; if (status !== 8'h28) begin n_fail++; $display("FAIL same_arm_abort: got %h exp 28", status); end
        do_arm;
        tick;
        tick;
        do_arm;
        n_tests++; if (status !== 8'hC2 || tg_enable !== 1'b1) begin n_fail++; $display("FAIL same_arm_ign: got %h/%b exp c2/1", status, tg_enable); end
        do_abort;
        timeout = 32'd20;
        trig_width = 16'd3;
        do_arm;
        tick;
        tick;
        repeat (19) tick;
        n_tests++; if (status[2:0] !== 3'd2) begin n_fail++; $display("FAIL same_pre: got st=%0d exp 2", status[2:0]); end
        det = 8'h10;
        tick;
        det = 8'h00;
        n_tests++; if (status !== 8'h83 || trig_out !== 1'b1) begin n_fail++; $display("FAIL same_det_to: got %h/%b exp 83/1", status, trig_out); end
        guard = 0;
        while (status[2:0] != 3'd0 && guard < 30) begin
            tick;
            guard++;
        end
        timeout = 32'd0;
        n_tests++; if (shot_cnt !== 16'd4 || status !== 8'h08) begin n_fail++; $display("FAIL same_end: got %0d/%h exp 4/08", shot_cnt, status); end
    endtask
    task automatic test_rst_mid;
        trig_width = 16'd10;
        tof_in = 32'h1234_5678;
        do_arm;
        tick;
        tick;
        det = 8'h10;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        det = 8'h00;
        n_tests++; if (trig_out !== 1'b0 || tg_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs: got trig=%b en=%b exp 0/0", trig_out, tg_enable); end
        n_tests++; if (tof_captured !== 32'h0000FFFF || shot_cnt !== 16'd0 || status !== 8'h00) begin n_fail++; $display("FAIL rst_mid_regs: got %h/%0d/%h exp ffff/0/00", tof_captured, shot_cnt, status); end
    endtask
    initial begin
        rst = 1'b1; arm = 1'b0; abort_c = 1'b0; auto_rearm = 1'b0;
        trig_width = 16'd1; timeout = 32'd0; det = 8'h00; tof_in = 32'd0;
        level_a = 32'd0; level_b = 32'h0B0B_0B0B; level_c = 32'h0C0C_0C0C;
        param_mul = 32'd0; param_off = 32'h0000_0100; init_delay = 32'd0;
        test_reset;
        test_basic_shot;
        test_timeout;
        test_abort_fire;
        test_shadow;
        test_auto_rearm;
        test_same_cycle;
        test_rst_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
